// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage core.
// Generates PC / IF/ID / ID/EX control from hazard, jump, branch and external
// stall requests, tracks consecutive stall length and raises a sticky
// watchdog flag. Optional perf counters are built when PIPE_CTRL_PERF_EN
// is defined; otherwise both counter ports read as zero.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned STALL_LIMIT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        hazard_i,
    input  logic        jump_i,
    input  logic        branch_taken_i,
    input  logic        ext_stall_i,
    output logic        pc_we_o,
    output logic        if_id_we_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic        pipe_freeze_o,
    output logic        stall_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]       DEPTH    = 2'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);
    localparam state_t           REDIRECT = (FLUSH_DEPTH == 0) ? RUN : FLUSH;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       flush_cnt, flush_cnt_nx;
    logic             timeout, timeout_nx;
    logic             stall_inc, flush_inc;

    // State, stall-run counter, flush countdown and watchdog flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= RUN;
            cnt       <= '0;
            flush_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            flush_cnt <= flush_cnt_nx;
            timeout   <= timeout_nx;
        end
    end

    // Request arbitration: next state and same-cycle control outputs
    always_comb begin
        pc_we_o        = 1'b0;
        if_id_we_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
        state_nx       = state;
        cnt_nx         = cnt;
        flush_cnt_nx   = flush_cnt;
        timeout_nx     = timeout;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (!rst_n_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (ext_stall_i) begin
            pipe_freeze_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_we_o        = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            flush_inc      = 1'b1;
            cnt_nx         = '0;
            flush_cnt_nx   = DEPTH;
            state_nx       = REDIRECT;
        end else if (hazard_i && state != FLUSH) begin
            // IF/ID holds a NOP while flushing, so a hazard there is spurious
            id_ex_bubble_o = 1'b1;
            stall_inc      = 1'b1;
            state_nx       = STALL;
            if (cnt != '1) begin
                cnt_nx = cnt + 1'b1;
            end
            if (cnt == LIMIT_M1) begin
                timeout_nx = 1'b1;
            end
        end else if (jump_i) begin
            pc_we_o       = 1'b1;
            if_id_flush_o = 1'b1;
            flush_inc     = 1'b1;
            cnt_nx        = '0;
            flush_cnt_nx  = DEPTH;
            state_nx      = REDIRECT;
        end else if (state == FLUSH) begin
            pc_we_o       = 1'b1;
            if_id_flush_o = 1'b1;
            cnt_nx        = '0;
            flush_cnt_nx  = flush_cnt - 1'b1;
            if (flush_cnt == 2'd1) begin
                state_nx = RUN;
            end
        end else begin
            pc_we_o    = 1'b1;
            if_id_we_o = 1'b1;
            cnt_nx     = '0;
            state_nx   = RUN;
        end
    end

    assign stall_timeout_o = timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;

    // Free-running perf counters, wrap modulo 2^32
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_inc) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles;
    assign flush_events_o = flush_events;
`else
    logic unused_perf;
    assign unused_perf    = stall_inc ^ flush_inc;
    assign stall_cycles_o = 32'h0;
    assign flush_events_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl.
// The driver computes expected outputs from a reference model and queues
// them; the monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    localparam int unsigned FD    = 1;
    localparam int unsigned LIMIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hazard = 1'b0, jump = 1'b0, branch = 1'b0, ext_stall = 1'b0;
    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze;
    logic        stall_timeout;
    logic [31:0] stall_cycles, flush_events;

    pipeline_ctrl #(
        .FLUSH_DEPTH(FD),
        .STALL_LIMIT(LIMIT),
        .CNT_W      (8)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .hazard_i       (hazard),
        .jump_i         (jump),
        .branch_taken_i (branch),
        .ext_stall_i    (ext_stall),
        .pc_we_o        (pc_we),
        .if_id_we_o     (if_id_we),
        .if_id_flush_o  (if_id_flush),
        .id_ex_bubble_o (id_ex_bubble),
        .pipe_freeze_o  (pipe_freeze),
        .stall_timeout_o(stall_timeout),
        .stall_cycles_o (stall_cycles),
        .flush_events_o (flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [4:0]  ctrl;   // {pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}
        logic        to;
        logic [31:0] sc;
        logic [31:0] fe;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    endtask

    // Reference model state (0 run, 1 stall, 2 flush)
    int          m_state = 0;
    int          m_run   = 0;
    int          m_frem  = 0;
    logic        m_to    = 1'b0;
    logic [31:0] m_sc    = '0;
    logic [31:0] m_fe    = '0;

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic redirect();
        m_fe  = m_fe + 32'd1;
        m_run = 0;
        if (FD > 0) begin
            m_state = 2;
            m_frem  = FD;
        end else begin
            m_state = 0;
        end
    endtask

    // One clock cycle of stimulus with its expected response
    task automatic drive(input string tag, input logic h, input logic j, input logic b, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        hazard    = h;
        jump      = j;
        branch    = b;
        ext_stall = e;
        x.tag = tag;
        x.to  = m_to;
        x.sc  = perf(m_sc);
        x.fe  = perf(m_fe);
        if (e) begin
            x.ctrl = 5'b00001;
        end else if (b) begin
            x.ctrl = 5'b10110;
            redirect();
        end else if (h && m_state != 2) begin
            x.ctrl = 5'b00010;
            if (m_run == int'(LIMIT) - 1) m_to = 1'b1;
            if (m_run < 255) m_run++;
            m_sc    = m_sc + 32'd1;
            m_state = 1;
        end else if (j) begin
            x.ctrl = 5'b10100;
            redirect();
        end else if (m_state == 2) begin
            x.ctrl = 5'b10100;
            m_run  = 0;
            if (m_frem == 1) m_state = 0;
            m_frem--;
        end else begin
            x.ctrl  = 5'b11000;
            m_run   = 0;
            m_state = 0;
        end
        exp_q.push_back(x);
    endtask

    // Assert reset for one cycle; outputs must take reset values at once
    task automatic do_rst(input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        hazard    = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        ext_stall = 1'b0;
        m_state = 0; m_run = 0; m_frem = 0; m_to = 1'b0; m_sc = '0; m_fe = '0;
        x.tag  = tag;
        x.ctrl = 5'b00110;
        x.to   = 1'b0;
        x.sc   = 32'h0;
        x.fe   = 32'h0;
        exp_q.push_back(x);
        #1;
        check({tag, ".now.ctrl"}, {27'b0, pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}, 32'b00110);
        check({tag, ".now.timeout"}, {31'b0, stall_timeout}, 32'h0);
        check({tag, ".now.stall_cycles"}, stall_cycles, 32'h0);
        check({tag, ".now.flush_events"}, flush_events, 32'h0);
    endtask

    // Monitor: compare DUT outputs mid-cycle against queued expectations
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check({x.tag, ".ctrl"}, {27'b0, pc_we, if_id_we, if_id_flush, id_ex_bubble, pipe_freeze}, {27'b0, x.ctrl});
            check({x.tag, ".timeout"}, {31'b0, stall_timeout}, {31'b0, x.to});
            check({x.tag, ".stall_cycles"}, stall_cycles, x.sc);
            check({x.tag, ".flush_events"}, flush_events, x.fe);
        end
    end

    initial begin
        do_rst("rst0");
        drive("idle0", 0, 0, 0, 0);

        // Two-cycle RAW stall then resume
        drive("haz1", 1, 0, 0, 0);
        drive("haz2", 1, 0, 0, 0);
        drive("haz_done", 0, 0, 0, 0);

        // Taken branch with one extra flush cycle
        drive("br", 0, 0, 1, 0);
        drive("br_fl", 0, 0, 0, 0);
        drive("br_run", 0, 0, 0, 0);

        // Branch beats hazard; hazard ignored while flushing
        drive("br_haz", 1, 0, 1, 0);
        drive("fl_haz", 1, 0, 0, 0);
        drive("after_fl", 0, 0, 0, 0);

        // Ext stall during STALL freezes the run counter
        drive("s4_h1", 1, 0, 0, 0);
        drive("s4_h2", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("s4_ext", 1, 0, 0, 1);
        for (int i = 0; i < 14; i++) drive("s4_hold", 1, 0, 0, 0);
        drive("s4_sticky", 0, 0, 0, 0);
        drive("s4_sticky2", 0, 0, 0, 0);

        // Jumps, jump under hazard, ext stall while flushing
        drive("jmp", 0, 1, 0, 0);
        drive("jmp_fl", 0, 0, 0, 0);
        drive("jmp_haz", 1, 1, 0, 0);
        drive("jmp_haz2", 0, 0, 0, 0);
        drive("jmp_fl2", 0, 0, 0, 0);
        drive("fl_br", 0, 0, 1, 0);
        drive("fl_ext", 0, 1, 0, 1);
        drive("fl_jmp", 0, 1, 0, 0);
        drive("fl_end", 0, 0, 0, 0);
        drive("run_end", 0, 0, 0, 0);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            drive("rnd",
                  logic'($urandom_range(99) < 40),
                  logic'($urandom_range(99) < 10),
                  logic'($urandom_range(99) < 8),
                  logic'($urandom_range(99) < 10));
        end

        // Reset pulsed in the middle of a flush
        drive("pre_rst_br", 0, 0, 1, 0);
        do_rst("rst_mid");
        drive("post_rst", 0, 0, 0, 0);
        drive("post_rst2", 1, 0, 0, 0);
        drive("post_rst3", 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
